mem_arbiter_rr: RTL and testbench

- N-channel round-robin arbiter between the split L1 caches (and optional extra masters, e.g. a prefetcher) and the shared L2/physical-memory port.
- Generalises the two-port I/D arbiter to a parametrised channel count, address width and line width.
- Latches the winning request into a grant register, holds it to the L2 until `l2_mem_resp`, and rotates priority fairly so that no channel can starve another.

---
 rtl/mem_arbiter_rr.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter_rr.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter between NUM_CH cache channels and one shared L2 port.
// One transaction at a time: IDLE picks a winner, BUSY holds it until l2_mem_resp, DONE adds one bubble.
module mem_arbiter_rr #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 128,
    parameter int ID_W   = $clog2(NUM_CH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          req_read,
    input  logic [NUM_CH-1:0]          req_write,
    input  logic [NUM_CH*ADDR_W-1:0]   req_address,
    input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
    output logic [NUM_CH-1:0]          req_resp,
    output logic [DATA_W-1:0]          req_rdata,
    output logic                       l2_mem_read,
    output logic                       l2_mem_write,
    output logic [ADDR_W-1:0]          l2_mem_address,
    output logic [DATA_W-1:0]          l2_mem_wdata,
    input  logic [DATA_W-1:0]          l2_mem_rdata,
    input  logic                       l2_mem_resp,
    output logic [ID_W-1:0]            grant_id,
    output logic                       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ID_W:0] NUM_CH_V = (ID_W+1)'(NUM_CH);

    state_t              state;
    state_t              state_next;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     grant_q;
    logic                op_write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic [NUM_CH-1:0]   req_any;
    logic [ID_W-1:0]     cand;
    logic [ID_W-1:0]     winner;
    logic                found;
    logic                win_write;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;

    // Offsets never exceed NUM_CH-1, so one conditional subtract is a full modulo.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                 input logic [ID_W:0]   off);
        logic [ID_W:0] sum;
        sum = {1'b0, base} + off;
        if (sum >= NUM_CH_V) sum = sum - NUM_CH_V;
        return sum[ID_W-1:0];
    endfunction

    assign req_any = req_read | req_write;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = wrap_add(ptr, (ID_W+1)'(i));
            if (!found && req_any[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // A simultaneous read+write on one channel is issued as the write-back.
    always_comb begin
        win_write = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (winner == ID_W'(k)) begin
                win_write = req_write[k];
                win_addr  = req_address[k*ADDR_W +: ADDR_W];
                win_wdata = req_wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = BUSY;
            BUSY:    if (l2_mem_resp) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= '0;
            grant_q    <= '0;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            if (state == IDLE && found) begin
                grant_q    <= winner;
                op_write_q <= win_write;
                addr_q     <= win_addr;
                wdata_q    <= win_wdata;
            end
            if (state == BUSY && l2_mem_resp) ptr <= wrap_add(grant_q, (ID_W+1)'(1));
        end
    end

    always_comb begin
        l2_mem_read  = 1'b0;
        l2_mem_write = 1'b0;
        busy         = 1'b0;
        req_resp     = '0;
        if (state == BUSY) begin
            busy         = 1'b1;
            l2_mem_read  = !op_write_q;
            l2_mem_write = op_write_q;
            for (int k = 0; k < NUM_CH; k++) begin
                req_resp[k] = l2_mem_resp && (grant_q == ID_W'(k));
            end
        end
    end

    assign l2_mem_address = addr_q;
    assign l2_mem_wdata   = wdata_q;
    assign req_rdata      = l2_mem_rdata;
    assign grant_id       = grant_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: a 2-channel and a 4-channel instance checked every cycle
// against a transaction-level model, plus directed scenarios with literal expectations.
module tb_mem_arbiter_rr;

    localparam int AW = 16;
    localparam int DW = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // instance 0: NUM_CH=2, instance 1: NUM_CH=4
    logic [3:0]    d_rd [2];
    logic [3:0]    d_wr [2];
    logic [AW-1:0] d_ad [2][4];
    logic [DW-1:0] d_wd [2][4];
    logic          l2_resp_v [2];
    logic [DW-1:0] l2_rdata_v [2];
    int            lat [2];
    logic [DW-1:0] line_val [2];
    logic          force_stray [2];
    logic          rand_data;
    logic          stray_en;

    logic [1:0]    resp2;
    logic [DW-1:0] rdata2, l2wd2;
    logic          l2r2, l2w2, busy2;
    logic [AW-1:0] l2a2;
    logic [0:0]    gid2;

    logic [3:0]    resp4;
    logic [DW-1:0] rdata4, l2wd4;
    logic          l2r4, l2w4, busy4;
    logic [AW-1:0] l2a4;
    logic [1:0]    gid4;

    mem_arbiter_rr #(.NUM_CH(2), .ADDR_W(AW), .DATA_W(DW)) dut2 (
        .clk(clk), .rst(rst),
        .req_read(d_rd[0][1:0]), .req_write(d_wr[0][1:0]),
        .req_address({d_ad[0][1], d_ad[0][0]}),
        .req_wdata({d_wd[0][1], d_wd[0][0]}),
        .req_resp(resp2), .req_rdata(rdata2),
        .l2_mem_read(l2r2), .l2_mem_write(l2w2),
        .l2_mem_address(l2a2), .l2_mem_wdata(l2wd2),
        .l2_mem_rdata(l2_rdata_v[0]), .l2_mem_resp(l2_resp_v[0]),
        .grant_id(gid2), .busy(busy2)
    );

    mem_arbiter_rr #(.NUM_CH(4), .ADDR_W(AW), .DATA_W(DW)) dut4 (
        .clk(clk), .rst(rst),
        .req_read(d_rd[1]), .req_write(d_wr[1]),
        .req_address({d_ad[1][3], d_ad[1][2], d_ad[1][1], d_ad[1][0]}),
        .req_wdata({d_wd[1][3], d_wd[1][2], d_wd[1][1], d_wd[1][0]}),
        .req_resp(resp4), .req_rdata(rdata4),
        .l2_mem_read(l2r4), .l2_mem_write(l2w4),
        .l2_mem_address(l2a4), .l2_mem_wdata(l2wd4),
        .l2_mem_rdata(l2_rdata_v[1]), .l2_mem_resp(l2_resp_v[1]),
        .grant_id(gid4), .busy(busy4)
    );

    logic [3:0]    o_resp [2];
    logic          o_rd [2], o_wr [2], o_busy [2];
    logic [AW-1:0] o_ad [2];
    logic [DW-1:0] o_wd [2], o_rdata [2];
    logic [1:0]    o_gid [2];

    assign o_resp[0] = {2'b00, resp2};  assign o_resp[1] = resp4;
    assign o_rd[0]   = l2r2;            assign o_rd[1]   = l2r4;
    assign o_wr[0]   = l2w2;            assign o_wr[1]   = l2w4;
    assign o_busy[0] = busy2;           assign o_busy[1] = busy4;
    assign o_ad[0]   = l2a2;            assign o_ad[1]   = l2a4;
    assign o_wd[0]   = l2wd2;           assign o_wd[1]   = l2wd4;
    assign o_rdata[0] = rdata2;         assign o_rdata[1] = rdata4;
    assign o_gid[0]  = {1'b0, gid2};    assign o_gid[1]  = gid4;

    task automatic chk(input string name, input int k,
                       input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (ch_count=%0d): got %h expected %h", name, k == 0 ? 2 : 4, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    function automatic int nch(input int k);
        return (k == 0) ? 2 : 4;
    endfunction

    logic          m_act [2];   // a transaction is outstanding at the L2
    logic          m_bub [2];   // one idle cycle after a completion
    logic          m_wr [2];
    int            m_ptr [2];
    int            m_ch [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_wdata [2];

    function automatic logic bit_of(input logic [3:0] v, input int c);
        return ((v >> c) & 4'd1) != 4'd0;
    endfunction

    function automatic int pick(input int k);
        int n;
        int c;
        n = nch(k);
        for (int i = 0; i < n; i++) begin
            c = (m_ptr[k] + i) % n;
            if (bit_of(d_rd[k] | d_wr[k], c)) return c;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_act[k]   <= 1'b0;
                m_bub[k]   <= 1'b0;
                m_wr[k]    <= 1'b0;
                m_ptr[k]   <= 0;
                m_ch[k]    <= 0;
                m_addr[k]  <= '0;
                m_wdata[k] <= '0;
            end else if (m_act[k]) begin
                if (l2_resp_v[k]) begin
                    m_act[k] <= 1'b0;
                    m_bub[k] <= 1'b1;
                    m_ptr[k] <= (m_ch[k] + 1) % nch(k);
                end
            end else if (m_bub[k]) begin
                m_bub[k] <= 1'b0;
            end else if (pick(k) >= 0) begin
                m_act[k]   <= 1'b1;
                m_ch[k]    <= pick(k);
                m_wr[k]    <= bit_of(d_wr[k], pick(k));
                m_addr[k]  <= d_ad[k][pick(k)];
                m_wdata[k] <= d_wd[k][pick(k)];
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                chk("l2_mem_read", k, o_rd[k], m_act[k] & ~m_wr[k]);
                chk("l2_mem_write", k, o_wr[k], m_act[k] & m_wr[k]);
                chk("busy", k, o_busy[k], m_act[k]);
                chk("l2_mem_address", k, o_ad[k], m_addr[k]);
                chk("l2_mem_wdata", k, o_wd[k], m_wdata[k]);
                chk("req_resp", k, o_resp[k], (m_act[k] && l2_resp_v[k]) ? (4'd1 << m_ch[k]) : 4'd0);
                chk("req_rdata", k, o_rdata[k], l2_rdata_v[k]);
                chk("grant_id", k, o_gid[k], m_ch[k]);
            end
        end
    end

    // grant log and last-seen response, sampled at the same edge as the compare
    int         grq [2][$];
    logic [3:0] last_resp [2];
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            last_resp[k] = o_resp[k];
            for (int c = 0; c < 4; c++) if (bit_of(o_resp[k], c)) grq[k].push_back(c);
        end
    end

    // ---------------- L2 responder ----------------
    initial begin
        int wc [2];
        wc = '{0, 0};
        l2_resp_v  = '{1'b0, 1'b0};
        l2_rdata_v = '{'0, '0};
        forever begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                l2_resp_v[k]  = 1'b0;
                l2_rdata_v[k] = rand_data ? {$urandom, $urandom, $urandom, $urandom} : line_val[k];
                if (rst) wc[k] = 0;
                else if (o_rd[k] | o_wr[k]) begin
                    if (wc[k] >= lat[k]) begin
                        l2_resp_v[k] = 1'b1;
                        wc[k] = 0;
                    end else wc[k]++;
                end else begin
                    wc[k] = 0;
                    if (force_stray[k] || (stray_en && $urandom_range(0, 7) == 0)) l2_resp_v[k] = 1'b1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_resp(input int k, input int ch, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bit_of(o_resp[k], ch)) begin
                ok = 1'b1;
                return;
            end
        end
        n_checks++;
        n_err++;
        $display("FAIL resp_timeout: channel %0d got no response within 60 cycles, required one", ch);
    endtask

    task automatic wait_any(input int k, output int ch, output logic ok);
        ok = 1'b0;
        ch = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) if (bit_of(o_resp[k], c)) ch = c;
            if (ch >= 0) begin
                ok = 1'b1;
                return;
            end
        end
        n_checks++;
        n_err++;
        $display("FAIL any_resp_timeout: no response within 60 cycles, required one");
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        repeat (3) tick();
    endtask

    task automatic check_grants(input string name, input int k, input int exp_g[$]);
        chk({name, "_count"}, k, grq[k].size() >= exp_g.size(), 1'b1);
        for (int i = 0; i < exp_g.size() && i < grq[k].size(); i++) chk(name, k, grq[k][i], exp_g[i]);
    endtask

    logic          pending [2][4];
    logic          ok;
    int            ch;
    int            rw;

    initial begin
        for (int k = 0; k < 2; k++) begin
            d_rd[k] = '0;
            d_wr[k] = '0;
            lat[k] = 2;
            line_val[k] = '0;
            force_stray[k] = 1'b0;
            for (int c = 0; c < 4; c++) begin
                d_ad[k][c] = '0;
                d_wd[k][c] = '0;
                pending[k][c] = 1'b0;
            end
        end
        rand_data = 1'b0;
        stray_en  = 1'b0;

        // reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_busy", 0, busy2, 1'b0);
        chk("rst_l2_read", 0, l2r2, 1'b0);
        chk("rst_resp", 0, resp2, 2'b00);
        chk("rst_grant", 1, gid4, 2'd0);
        chk("rst_addr", 1, l2a4, 16'h0000);
        rst = 1'b0;

        // single read on channel 0
        line_val[0] = {16{8'hA5}};
        d_rd[0] = 4'b0001;
        d_ad[0][0] = 16'h1230;
        @(negedge clk);
        chk("t1_no_strobe_yet", 0, l2r2, 1'b0);
        @(negedge clk);
        chk("t1_strobe", 0, l2r2, 1'b1);
        chk("t1_addr", 0, l2a2, 16'h1230);
        chk("t1_grant", 0, gid2, 1'b0);
        wait_resp(0, 0, ok);
        if (ok) begin
            chk("t1_resp", 0, resp2, 2'b01);
            chk("t1_rdata", 0, rdata2, {16{8'hA5}});
        end
        tick();
        d_rd[0] = '0;
        @(negedge clk);
        chk("t1_busy_fall", 0, busy2, 1'b0);
        settle();

        // simultaneous requests straight after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        d_rd[0] = 4'b0001;  d_ad[0][0] = 16'h0040;
        d_wr[0] = 4'b0010;  d_ad[0][1] = 16'h8000;  d_wd[0][1] = {4{32'hDEADBEEF}};
        wait_resp(0, 0, ok);
        if (ok) chk("t2_first_grant", 0, gid2, 1'b0);
        tick();
        d_rd[0] = '0;
        wait_resp(0, 1, ok);
        if (ok) begin
            chk("t2_write", 0, l2w2, 1'b1);
            chk("t2_addr", 0, l2a2, 16'h8000);
            chk("t2_wdata", 0, l2wd2, {4{32'hDEADBEEF}});
            chk("t2_resp", 0, resp2, 2'b10);
        end
        tick();
        d_wr[0] = '0;
        settle();

        // starvation: ch1 holds, ch0 re-requests right after each response
        grq[0].delete();
        d_rd[0] = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            wait_any(0, ch, ok);
            tick();
            if (i == 3) d_rd[0] = '0;
            else if (ch == 0) begin
                d_rd[0] = 4'b0010;
                tick();
                d_rd[0] = 4'b0011;
            end
        end
        check_grants("t3_grant_seq", 0, '{0, 1, 0, 1});
        settle();

        // read+write together becomes a write; a dropped request still completes
        d_rd[0] = 4'b0010;  d_wr[0] = 4'b0010;  d_ad[0][1] = 16'h2222;
        repeat (2) @(negedge clk);
        chk("t4_write_wins_w", 0, l2w2, 1'b1);
        chk("t4_write_wins_r", 0, l2r2, 1'b0);
        wait_resp(0, 1, ok);
        tick();
        d_rd[0] = '0;  d_wr[0] = '0;
        settle();
        lat[0] = 4;
        d_wr[0] = 4'b0010;  d_ad[0][1] = 16'h3333;
        repeat (2) @(negedge clk);
        tick();
        d_wr[0] = '0;
        @(negedge clk);
        chk("t4_drop_write_held", 0, l2w2, 1'b1);
        wait_resp(0, 1, ok);
        if (ok) chk("t4_drop_resp", 0, resp2, 2'b10);
        settle();

        // asynchronous reset in the middle of a transaction
        lat[0] = 6;
        d_rd[0] = 4'b0001;  d_ad[0][0] = 16'h4444;
        repeat (2) @(negedge clk);
        chk("t5_busy_before", 0, busy2, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_read", 0, l2r2, 1'b0);
        chk("t5_async_busy", 0, busy2, 1'b0);
        chk("t5_async_resp", 0, resp2, 2'b00);
        chk("t5_async_addr", 0, l2a2, 16'h0000);
        d_rd[0] = '0;
        tick();
        tick();
        rst = 1'b0;
        lat[0] = 2;
        d_rd[0] = 4'b0010;  d_ad[0][1] = 16'h5555;
        repeat (2) @(negedge clk);
        chk("t5_grant_ch1", 0, gid2, 1'b1);
        chk("t5_read_ch1", 0, l2r2, 1'b1);
        wait_resp(0, 1, ok);
        tick();
        d_rd[0] = '0;
        settle();

        // four channels, all requesting continuously
        grq[1].delete();
        lat[1] = 1;
        for (int c = 0; c < 4; c++) d_ad[1][c] = AW'($urandom);
        d_rd[1] = 4'b1111;
        for (int i = 0; i < 5; i++) wait_any(1, ch, ok);
        tick();
        d_rd[1] = '0;
        check_grants("t6_grant_seq", 1, '{0, 1, 2, 3, 0});
        settle();
        @(negedge clk);
        force_stray[1] = 1'b1;
        @(negedge clk);
        chk("t6_stray_resp", 1, resp4, 4'b0000);
        chk("t6_stray_busy", 1, busy4, 1'b0);
        force_stray[1] = 1'b0;
        settle();

        // randomized traffic on both instances
        rand_data = 1'b1;
        stray_en  = 1'b1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < nch(k); c++) begin
                    if (pending[k][c] && bit_of(last_resp[k], c)) begin
                        pending[k][c] = 1'b0;
                        d_rd[k] = d_rd[k] & ~(4'd1 << c);
                        d_wr[k] = d_wr[k] & ~(4'd1 << c);
                    end else if (!pending[k][c] && $urandom_range(0, 3) == 0) begin
                        rw = $urandom_range(0, 3);
                        pending[k][c] = 1'b1;
                        d_ad[k][c] = AW'($urandom);
                        d_wd[k][c] = {$urandom, $urandom, $urandom, $urandom};
                        if (rw != 2) d_rd[k] = d_rd[k] | (4'd1 << c);
                        if (rw >= 2) d_wr[k] = d_wr[k] | (4'd1 << c);
                    end
                end
                lat[k] = $urandom_range(1, 4);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: simulation still running at 500000 time units, required completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
